// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word/dword loads and stores on a
// 64-bit word array, read-modify-write for sub-word stores.
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    MERGE,
    RESP
  } state_t;

  state_t state, stateNx;

  logic [63:0]      mem [DEPTH];
  logic [63:0]      rdWord;
  logic [63:0]      wdataR;
  logic [IDX_W-1:0] idxR;
  logic [2:0]       offR;
  logic [1:0]       sizeR;
  logic             wrR;
  logic             unsR;

  logic             accept;
  logic             misIn;
  logic             dwStore;
  logic             rdEn;
  logic [IDX_W-1:0] idxIn;
  logic [5:0]       shAmt;
  logic [63:0]      laneMask;
  logic [63:0]      lane;
  logic [63:0]      loadExt;
  logic [63:0]      merged;
  logic             unusedAddr;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready && !reset;
  assign idxIn      = req_addr[IDX_W+2:3];
  assign unusedAddr = ^req_addr[63:IDX_W+3];

  always_comb begin
    misIn = 1'b0;
    unique case (req_size)
      2'b01:   misIn = req_addr[0];
      2'b10:   misIn = |req_addr[1:0];
      2'b11:   misIn = |req_addr[2:0];
      default: misIn = 1'b0;
    endcase
  end

  assign dwStore = req_write && (req_size == 2'b11);
  assign rdEn    = accept && !misIn && !dwStore;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNx;
  end

  always_comb begin
    stateNx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (misIn || dwStore) stateNx = RESP;
          else                  stateNx = RD_WAIT;
        end
      end
      RD_WAIT: stateNx = wrR ? MERGE : RESP;
      MERGE:   stateNx = RESP;
      RESP:    stateNx = IDLE;
      default: stateNx = IDLE;
    endcase
  end

  assign shAmt = {offR, 3'b000};

  always_comb begin
    laneMask = 64'hFFFF_FFFF_FFFF_FFFF;
    unique case (sizeR)
      2'b00:   laneMask = 64'h0000_0000_0000_00FF;
      2'b01:   laneMask = 64'h0000_0000_0000_FFFF;
      2'b10:   laneMask = 64'h0000_0000_FFFF_FFFF;
      default: laneMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign lane   = rdWord >> shAmt;
  assign merged = (rdWord & ~(laneMask << shAmt))
                | ((wdataR & laneMask) << shAmt);

  always_comb begin
    loadExt = lane;
    unique case (sizeR)
      2'b00: loadExt = unsR ? {56'd0, lane[7:0]}
                            : {{56{lane[7]}}, lane[7:0]};
      2'b01: loadExt = unsR ? {48'd0, lane[15:0]}
                            : {{48{lane[15]}}, lane[15:0]};
      2'b10: loadExt = unsR ? {32'd0, lane[31:0]}
                            : {{32{lane[31]}}, lane[31:0]};
      default: loadExt = lane;
    endcase
  end

  // Array writes are suppressed under reset so an abandoned RMW leaves memory intact
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept && !misIn && dwStore) mem[idxIn] <= req_wdata;
      else if (state == MERGE)         mem[idxR]  <= merged;
    end
    if (rdEn) rdWord <= mem[idxIn];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wrR    <= req_write;
        sizeR  <= req_size;
        unsR   <= req_unsigned;
        idxR   <= idxIn;
        offR   <= req_addr[2:0];
        wdataR <= req_wdata;
        if (misIn) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end else if (dwStore) begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      end
      if (state == RD_WAIT && !wrR) begin
        resp_rdata <= loadExt;
        resp_err   <= 1'b0;
      end
      if (state == MERGE) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: byte-level memory model, per-cycle
// response/handshake checking, directed and random traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  dmem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          respCyc = -1;
  int          accCyc = 0;
  logic [63:0] expData = '0;
  logic        expErr = 1'b0;
  logic [63:0] heldData = '0;
  logic        heldErr = 1'b0;
  logic [63:0] m [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit v;
      v = (cyc == respCyc);
      if (v) begin
        heldData = expData;
        heldErr  = expErr;
      end
      chk("resp_valid", resp_valid, v);
      chk("req_ready", req_ready, cyc > respCyc);
      chk("resp_rdata", resp_rdata, heldData);
      chk("resp_err", resp_err, heldErr);
    end
  end

  task automatic predict(input logic w, input logic [1:0] sz,
                         input logic u, input logic [63:0] a,
                         input logic [63:0] wd, input bit commit,
                         output int lat, output logic [63:0] d,
                         output logic e);
    int n;
    int off;
    int idx;
    logic [63:0] word;
    n = 1 << sz;
    off = int'(a[2:0]);
    idx = int'(a[10:3]);
    word = m[idx];
    d = '0;
    e = 1'b0;
    if (a % n != 0) begin
      lat = 1;
      e = 1'b1;
    end else if (w) begin
      lat = (n == 8) ? 1 : 3;
      for (int b = 0; b < n; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
      if (commit) m[idx] = word;
    end else begin
      lat = 2;
      for (int b = 0; b < n; b++) d[8*b +: 8] = word[8*(off+b) +: 8];
      if (!u && d[8*n-1])
        for (int b = n; b < 8; b++) d[8*b +: 8] = 8'hFF;
    end
  endtask

  task automatic waitIdle(output bit ok);
    int n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (cyc <= respCyc) begin
      if (n++ > 20) begin
        tests++;
        fails++;
        $display("FAIL idle_timeout: still busy at cyc %0d", cyc);
        respCyc = -1;
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic doReq(input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] wd,
                       input bit hold = 0, input bit abort = 0);
    int lat;
    logic [63:0] d;
    logic e;
    bit ok;
    waitIdle(ok);
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    predict(w, sz, u, a, wd, !abort, lat, d, e);
    accCyc = cyc;
    respCyc = cyc + lat - 1;
    expData = d;
    expErr = e;
    if (!hold) req_valid = 1'b0;
    if (abort) begin
      @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      respCyc = -1;
      heldData = '0;
      heldErr = 1'b0;
      @(negedge clk);
      #1 reset = 1'b0;
    end
  endtask

  task automatic pin(input string name, input logic [63:0] lit,
                     input logic litErr, input int litLat);
    bit ok;
    chk({name, "_lat"}, respCyc - accCyc + 1, litLat);
    chk({name, "_model"}, expData, lit);
    waitIdle(ok);
    #1;
    chk({name, "_rdata"}, resp_rdata, lit);
    chk({name, "_err"}, resp_err, litErr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++)
      doReq(1, 2'b11, 0, 64'(i * 8), {$urandom, $urandom});

    doReq(1, 2'b11, 0, 64'h40, 64'h1122334455667788);
    pin("st_dw", 0, 0, 1);
    doReq(0, 2'b11, 0, 64'h40, 0);
    pin("ld_dw", 64'h1122334455667788, 0, 2);
    doReq(1, 2'b00, 0, 64'h43, 64'hAB);
    pin("st_b", 0, 0, 3);
    doReq(0, 2'b11, 0, 64'h40, 0);
    pin("ld_dw2", 64'h11223344AB667788, 0, 2);
    doReq(0, 2'b00, 0, 64'h43, 0);
    pin("ld_bs", 64'hFFFFFFFFFFFFFFAB, 0, 2);
    doReq(0, 2'b00, 1, 64'h43, 0);
    pin("ld_bu", 64'h00000000000000AB, 0, 2);
    doReq(0, 2'b01, 0, 64'h46, 0);
    pin("ld_hs", 64'h0000000000001122, 0, 2);
    doReq(0, 2'b10, 0, 64'h42, 0);
    pin("ld_mis", 0, 1, 1);
    doReq(0, 2'b11, 0, 64'h40, 0);
    pin("ld_after_mis", 64'h11223344AB667788, 0, 2);
    doReq(1, 2'b01, 0, 64'h44, 64'hBEEF, 0, 1);
    doReq(0, 2'b11, 0, 64'h40, 0);
    pin("ld_after_rst", 64'h11223344AB667788, 0, 2);
    doReq(1, 2'b11, 0, 64'h800, 64'hDEAD);
    doReq(0, 2'b11, 0, 64'h0, 0);
    pin("ld_wrap", 64'hDEAD, 0, 2);

    for (int i = 0; i < 8; i++)
      doReq(1'($urandom), 2'($urandom), 1'($urandom),
            64'($urandom_range(0, 31)) << 3, {$urandom, $urandom}, 1);
    doReq(0, 2'b11, 0, 64'h40, 0);

    for (int i = 0; i < 400; i++) begin
      logic [1:0]  sz;
      logic [63:0] a;
      sz = 2'($urandom);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << sz) - 1);
      if ($urandom_range(0, 1) != 0) a[63:7] = {$urandom, $urandom};
      doReq(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
            $urandom_range(0, 3) == 0);
    end
    doReq(0, 2'b11, 0, 64'h0, 0);
    waitIdle(ok);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
